// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg: shared FSM state type, excodes and access-size masks    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [4:0] ADEL = 5'h04;
  localparam logic [4:0] ADES = 5'h05;

  localparam logic [3:0] SIZE_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_HALF = 4'b0011;
  localparam logic [3:0] SIZE_WORD = 4'b1111;

  // Any mask other than byte/half collapses to a word access.
  function automatic logic [3:0] norm_size(input logic [3:0] wen);
    if (wen == SIZE_BYTE || wen == SIZE_HALF) begin
      return wen;
    end
    return SIZE_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] wen, input logic [1:0] off);
    case (norm_size(wen))
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return (off != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_if: data-side SRAM-like bus between MEM stage and bus |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_access_if;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_align: shifts the raw read word by byte offset, then        |
// | truncates to access size and sign/zero-extends. Rev 1.0          |
// +------------------------------------------------------------------+
module load_align
  import mem_pkg::*;
(
  input  wire [31:0] data_rdata,
  input  wire [1:0]  offset,
  input  wire [3:0]  size,
  input  wire [1:0]  sign,
  output logic [31:0] mem_rdata
);

  logic [31:0] w_shifted;
  logic        w_signed;

  assign w_shifted = data_rdata >> {offset, 3'b000};
  assign w_signed  = (sign == 2'b01);

  always_comb begin
    mem_rdata = w_shifted;
    case (norm_size(size))
      SIZE_BYTE: mem_rdata = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: mem_rdata = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:   mem_rdata = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access: MEM-stage load/store unit driving a split addr/data  |
// | handshake bus, with address-error detection. Rev 1.0             |
// +------------------------------------------------------------------+
module mem_access
  import mem_pkg::*;
(
  input  wire         clk,
  input  wire         reset,
  input  wire         ex_is_ram,
  input  wire         ex_ram_we,
  input  wire  [3:0]  ex_ram_wen,
  input  wire  [1:0]  ex_ram_sign,
  input  wire  [31:0] ex_alu_out,
  input  wire  [31:0] ex_rdata2,
  input  wire         ex_cp0_ex,
  input  wire         int_flush,
  mem_access_if.master bus,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_stall,
  output logic        mem_ex,
  output logic [4:0]  mem_excode,
  output logic [31:0] mem_badvaddr
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  w_size;
  logic [1:0]  w_off;
  logic        w_misaligned;
  logic        w_go;
  logic        w_data_done;
  logic [31:0] w_aligned;

  assign w_size       = norm_size(ex_ram_wen);
  assign w_off        = ex_alu_out[1:0];
  assign w_misaligned = is_misaligned(ex_ram_wen, w_off);
  assign w_go         = ex_is_ram & ~ex_cp0_ex & ~w_misaligned & ~int_flush;
  assign w_data_done  = (r_state == ST_DATA) & bus.data_data_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // DRAIN absorbs the response of a flushed access so the bus stays in step.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_next_state = bus.data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.data_addr_ok) begin
          w_next_state = ST_DATA;
        end else if (int_flush) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.data_data_ok) begin
          w_next_state = ST_IDLE;
        end else if (int_flush) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.data_data_ok) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.data_req   = ~reset & w_go & ((r_state == ST_IDLE) | (r_state == ST_ADDR));
  assign bus.data_wr    = ex_ram_we;
  assign bus.data_addr  = ex_alu_out;
  assign bus.data_wstrb = ex_ram_we ? (w_size << w_off) : 4'b0000;

  always_comb begin
    bus.data_wdata = ex_rdata2;
    case (w_size)
      SIZE_BYTE: bus.data_wdata = {4{ex_rdata2[7:0]}};
      SIZE_HALF: bus.data_wdata = {2{ex_rdata2[15:0]}};
      default:   bus.data_wdata = ex_rdata2;
    endcase
  end

  assign mem_stall       = ~reset & ((w_go & ~w_data_done) | (r_state == ST_DRAIN));
  assign mem_rdata_valid = ~reset & w_data_done & ~ex_ram_we;

  load_align u_load_align (
    .data_rdata (bus.data_rdata),
    .offset     (w_off),
    .size       (ex_ram_wen),
    .sign       (ex_ram_sign),
    .mem_rdata  (w_aligned)
  );

  assign mem_rdata    = mem_rdata_valid ? w_aligned : 32'h0;

  assign mem_ex       = ex_is_ram & ~ex_cp0_ex & w_misaligned;
  assign mem_excode   = mem_ex ? (ex_ram_we ? ADES : ADEL) : 5'h00;
  assign mem_badvaddr = mem_ex ? ex_alu_out : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_access: directed checks of the MEM-stage load/store unit  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_access;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ex_is_ram, ex_ram_we, ex_cp0_ex, int_flush;
  logic [3:0]  ex_ram_wen;
  logic [1:0]  ex_ram_sign;
  logic [31:0] ex_alu_out, ex_rdata2;
  logic [31:0] mem_rdata, mem_badvaddr;
  logic        mem_rdata_valid, mem_stall, mem_ex;
  logic [4:0]  mem_excode;

  mem_access_if bus();

  mem_access dut (
    .clk             (clk),
    .reset           (reset),
    .ex_is_ram       (ex_is_ram),
    .ex_ram_we       (ex_ram_we),
    .ex_ram_wen      (ex_ram_wen),
    .ex_ram_sign     (ex_ram_sign),
    .ex_alu_out      (ex_alu_out),
    .ex_rdata2       (ex_rdata2),
    .ex_cp0_ex       (ex_cp0_ex),
    .int_flush       (int_flush),
    .bus             (bus.master),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_stall       (mem_stall),
    .mem_ex          (mem_ex),
    .mem_excode      (mem_excode),
    .mem_badvaddr    (mem_badvaddr)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    ex_is_ram = 1'b0; ex_ram_we = 1'b0; ex_ram_wen = 4'b1111; ex_ram_sign = 2'b00;
    ex_alu_out = 32'h0; ex_rdata2 = 32'h0; ex_cp0_ex = 1'b0; int_flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
  endtask

  task automatic set_op(input logic we, input logic [3:0] wen, input logic [1:0] sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    ex_is_ram = 1'b1; ex_ram_we = we; ex_ram_wen = wen; ex_ram_sign = sgn;
    ex_alu_out = addr; ex_rdata2 = wd; ex_cp0_ex = 1'b0; int_flush = 1'b0;
  endtask

  // Load accepted immediately, response one cycle later.
  task automatic load2(input logic [3:0] wen, input logic [1:0] sgn, input logic [31:0] addr,
                       input logic [31:0] rd, output logic [31:0] got, output logic vld);
    set_op(1'b0, wen, sgn, addr, 32'h0);
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rd;
    smp;
    got = mem_rdata; vld = mem_rdata_valid;
    tick;
    idle_inputs;
  endtask

  logic [31:0] got;
  logic        vld;

  initial begin
    idle_inputs;
    reset = 1'b1;
    set_op(1'b0, 4'b1111, 2'b00, 32'h100, 32'h0);
    bus.data_addr_ok = 1'b1;
    smp;
    chk("rst_req",   bus.data_req,    32'd0);
    chk("rst_stall", mem_stall,       32'd0);
    chk("rst_valid", mem_rdata_valid, 32'd0);
    tick; tick;
    smp;
    chk("rst_state", dut.r_state, ST_IDLE);
    tick;
    reset = 1'b0;

    // Word load at 0x100: accepted in cycle 0, response in cycle 2
    smp;
    chk("lw_c0_req",   bus.data_req,   32'd1);
    chk("lw_c0_stall", mem_stall,      32'd1);
    chk("lw_c0_addr",  bus.data_addr,  32'h100);
    chk("lw_c0_wstrb", bus.data_wstrb, 32'h0);
    chk("lw_c0_wr",    bus.data_wr,    32'd0);
    tick;
    bus.data_addr_ok = 1'b0; bus.data_rdata = 32'h12345678;
    smp;
    chk("lw_c1_stall", mem_stall,       32'd1);
    chk("lw_c1_req",   bus.data_req,    32'd0);
    chk("lw_c1_valid", mem_rdata_valid, 32'd0);
    chk("lw_c1_rdata", mem_rdata,       32'h0);
    tick;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
    smp;
    chk("lw_c2_stall", mem_stall,       32'd0);
    chk("lw_c2_valid", mem_rdata_valid, 32'd1);
    chk("lw_c2_rdata", mem_rdata,       32'hDEADBEEF);
    tick;
    idle_inputs;

    // Sub-word load alignment and extension
    load2(4'b0001, 2'b01, 32'h103, 32'h80FFFFFF, got, vld);
    chk("lb_s_rdata", got, 32'hFFFFFF80);
    chk("lb_s_valid", {31'd0, vld}, 32'd1);
    load2(4'b0001, 2'b00, 32'h103, 32'h80FFFFFF, got, vld);
    chk("lb_u_rdata", got, 32'h00000080);
    load2(4'b0011, 2'b01, 32'h102, 32'h80011234, got, vld);
    chk("lh_s_rdata", got, 32'hFFFF8001);
    load2(4'b0011, 2'b00, 32'h000, 32'h1234F00D, got, vld);
    chk("lh_u_rdata", got, 32'h0000F00D);
    load2(4'b0001, 2'b10, 32'h101, 32'h0000FE00, got, vld);
    chk("lb_sign10_rdata", got, 32'h000000FE);

    // Half store at 0x202, then complete it
    set_op(1'b1, 4'b0011, 2'b00, 32'h202, 32'h1234ABCD);
    bus.data_addr_ok = 1'b1;
    smp;
    chk("sh_wstrb", bus.data_wstrb, 32'hC);
    chk("sh_wdata", bus.data_wdata, 32'hABCDABCD);
    chk("sh_wr",    bus.data_wr,    32'd1);
    chk("sh_req",   bus.data_req,   32'd1);
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFFFFFF;
    smp;
    chk("sh_done_valid", mem_rdata_valid, 32'd0);
    chk("sh_done_stall", mem_stall,       32'd0);
    chk("sh_done_rdata", mem_rdata,       32'h0);
    tick;
    idle_inputs;

    // Store lane/strobe formatting, checked combinationally with no access issued
    ex_ram_we = 1'b1; ex_ram_wen = 4'b0001; ex_alu_out = 32'h201; ex_rdata2 = 32'hAABBCC55;
    #1;
    chk("sb_wstrb", bus.data_wstrb, 32'h2);
    chk("sb_wdata", bus.data_wdata, 32'h55555555);
    ex_ram_wen = 4'b1111; ex_alu_out = 32'h8; ex_rdata2 = 32'hCAFEBABE;
    #1;
    chk("sw_wstrb", bus.data_wstrb, 32'hF);
    chk("sw_wdata", bus.data_wdata, 32'hCAFEBABE);
    ex_ram_wen = 4'b0101; ex_alu_out = 32'h4;
    #1;
    chk("sodd_wstrb", bus.data_wstrb, 32'hF);
    idle_inputs;

    // Address errors
    set_op(1'b0, 4'b1111, 2'b00, 32'h101, 32'h0);
    #1;
    chk("adel_ex",    mem_ex,       32'd1);
    chk("adel_code",  mem_excode,   32'h04);
    chk("adel_bad",   mem_badvaddr, 32'h101);
    chk("adel_req",   bus.data_req, 32'd0);
    chk("adel_stall", mem_stall,    32'd0);
    ex_ram_we = 1'b1;
    #1;
    chk("ades_code", mem_excode, 32'h05);
    ex_ram_we = 1'b0; ex_ram_wen = 4'b0011; ex_alu_out = 32'h103;
    #1;
    chk("lh_mis_ex", mem_ex, 32'd1);
    ex_ram_wen = 4'b0001;
    #1;
    chk("lb_ok_ex", mem_ex, 32'd0);
    ex_ram_wen = 4'b1111; ex_alu_out = 32'h101; ex_cp0_ex = 1'b1;
    #1;
    chk("cp0_mis_ex", mem_ex, 32'd0);
    ex_alu_out = 32'h100;
    #1;
    chk("cp0_req", bus.data_req, 32'd0);
    idle_inputs;
    tick;

    // Flush while in DATA, response three cycles later, then a fresh load
    set_op(1'b0, 4'b1111, 2'b00, 32'h300, 32'h0);
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0; int_flush = 1'b1;
    smp;
    chk("fl_req",   bus.data_req,    32'd0);
    chk("fl_stall", mem_stall,       32'd0);
    chk("fl_valid", mem_rdata_valid, 32'd0);
    tick;
    set_op(1'b0, 4'b1111, 2'b00, 32'h400, 32'h0);
    bus.data_addr_ok = 1'b1;
    smp;
    chk("dr1_state", dut.r_state,  ST_DRAIN);
    chk("dr1_req",   bus.data_req, 32'd0);
    chk("dr1_stall", mem_stall,    32'd1);
    tick;
    smp;
    chk("dr2_req",   bus.data_req, 32'd0);
    chk("dr2_stall", mem_stall,    32'd1);
    tick;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11111111;
    smp;
    chk("dr3_valid", mem_rdata_valid, 32'd0);
    chk("dr3_rdata", mem_rdata,       32'h0);
    chk("dr3_stall", mem_stall,       32'd1);
    chk("dr3_req",   bus.data_req,    32'd0);
    tick;
    bus.data_data_ok = 1'b0;
    smp;
    chk("nx_req",   bus.data_req,  32'd1);
    chk("nx_addr",  bus.data_addr, 32'h400);
    chk("nx_stall", mem_stall,     32'd1);
    tick;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFEF00D;
    smp;
    chk("nx_valid", mem_rdata_valid, 32'd1);
    chk("nx_rdata", mem_rdata,       32'hCAFEF00D);
    tick;
    idle_inputs;

    // Reset while waiting in ADDR
    set_op(1'b0, 4'b1111, 2'b00, 32'h500, 32'h0);
    smp;
    chk("ra_req0", bus.data_req, 32'd1);
    tick;
    smp;
    chk("ra_state", dut.r_state,  ST_ADDR);
    chk("ra_req1",  bus.data_req, 32'd1);
    tick;
    reset = 1'b1;
    smp;
    chk("ra_rst_req",   bus.data_req, 32'd0);
    chk("ra_rst_stall", mem_stall,    32'd0);
    tick;
    reset = 1'b0; ex_is_ram = 1'b0; bus.data_data_ok = 1'b1;
    smp;
    chk("ra_post_state", dut.r_state,     ST_IDLE);
    chk("ra_post_req",   bus.data_req,    32'd0);
    chk("ra_post_stall", mem_stall,       32'd0);
    chk("ra_post_valid", mem_rdata_valid, 32'd0);
    tick;
    smp;
    chk("stray_ok_state", dut.r_state, ST_IDLE);
    idle_inputs;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ex_is_ram  in  1  the instruction held in the EX/MEM register is a load/store.
REQ-004 ex_ram_we  in  1  1 = store, 0 = load.
REQ-005 ex_ram_wen  in  4  size mask, unshifted: 4'b0001 byte, 4'b0011 half, 4'b1111 word; other values are treated as word.
REQ-006 ex_ram_sign  in  2  2'b01 = sign-extend load; any other value = zero-extend.
REQ-007 ex_alu_out  in  32  effective byte address.
REQ-008 ex_rdata2  in  32  store data, right-justified.
REQ-009 ex_cp0_ex  in  1  an older exception is pending; suppresses the access.
REQ-010 int_flush  in  1  pipeline flush.
REQ-011 data_req  out  1  bus request.
REQ-012 data_wr  out  1  bus write.
REQ-013 data_wstrb  out  4  byte strobes.
REQ-014 data_addr  out  32  bus address, equal to ex_alu_out.
REQ-015 data_wdata  out  32  replicated store data.
REQ-016 data_addr_ok  in  1  request accepted.
REQ-017 data_data_ok  in  1  response complete.
REQ-018 data_rdata  in  32  raw read word.
REQ-019 mem_rdata  out  32  aligned, extended load result.
REQ-020 mem_rdata_valid  out  1  one-cycle pulse; mem_rdata is valid in that cycle.
REQ-021 mem_stall  out  1  holds the EX/MEM register and earlier stages.
REQ-022 mem_ex / mem_excode / mem_badvaddr  out  1/5/32  address-error report.

Function
REQ-023 Misalignment is defined as: word access with addr[1:0] != 0, or half access with addr[0] != 0; byte accesses are never misaligned.
REQ-024 A misaligned access with ex_is_ram=1 and ex_cp0_ex=0 SHALL assert mem_ex combinationally, with mem_badvaddr = address and mem_excode = 5'h04 (AdEL) for loads or 5'h05 (AdES) for stores; no bus request is issued.
REQ-025 go = ex_is_ram & ~ex_cp0_ex & ~misaligned & ~int_flush.
REQ-026 The FSM has states IDLE, ADDR, DATA and DRAIN; reset enters IDLE.
REQ-027 data_req = go & (state == IDLE or ADDR).
REQ-028 IDLE -> DATA when go & addr_ok; IDLE -> ADDR when go & ~addr_ok.
REQ-029 ADDR -> DATA on addr_ok; ADDR -> IDLE if int_flush and no addr_ok in that cycle.
REQ-030 DATA -> IDLE on data_ok; DATA -> DRAIN if int_flush and no data_ok in that cycle.
REQ-031 DRAIN -> IDLE on data_ok; the response is discarded and mem_rdata_valid stays 0.
REQ-032 mem_stall = (go & ~(state == DATA & data_ok)) | (state == DRAIN).
REQ-033 On the data_ok edge the EX/MEM register advances together with the FSM return to IDLE, so exactly one access is made per instruction.
REQ-034 data_wstrb = (ex_wen << addr[1:0]) for stores and 4'b0000 for loads.
REQ-035 data_wdata = {4{byte}} for byte, {2{half}} for half, and the full word for word stores.
REQ-036 Loads: mem_rdata = (data_rdata >> 8*addr[1:0]), truncated to the access size, then sign- or zero-extended; the result is combinational and valid when state == DATA & data_ok.
REQ-037 mem_rdata_valid = (state == DATA) & data_ok & ~ex_ram_we.
REQ-038 When mem_rdata_valid = 0, mem_rdata SHALL be 32'h0.
REQ-039 A data_addr_ok or data_data_ok received in an unexpected state SHALL be ignored.

Reset
REQ-040 While reset is high the FSM SHALL be in IDLE and data_req, mem_stall and mem_rdata_valid SHALL be 0; the combinational outputs follow the inputs.
REQ-041 A reset asserted mid-transaction SHALL abandon the transaction and return to IDLE on the next edge; the bus is reset by the same reset.

Structure
REQ-042 A shared package mem_pkg SHALL hold the FSM state type, the excode constants ADEL = 5'h04 and ADES = 5'h05, and the size-mask constants.
REQ-043 A single combinational sub-module load_align SHALL take (data_rdata, offset, size, sign) and produce mem_rdata.

Verification
REQ-044 Load word from address 0x100, addr_ok at cycle 0, data_ok at cycle 2 with rdata 0xDEADBEEF -> mem_stall high for cycles 0 and 1, mem_rdata = 0xDEADBEEF with the valid pulse in cycle 2.
REQ-045 Signed byte load from address 0x103 with rdata 0x80FFFFFF -> mem_rdata = 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-046 Half store from address 0x202, rdata2 = 0x1234ABCD -> data_wstrb = 4'b1100 and data_wdata = 0xABCDABCD.
REQ-047 Load word from address 0x101 -> mem_ex = 1, mem_excode = 0x04, mem_badvaddr = 0x101, no data_req; a store to the same address -> mem_excode = 0x05.
REQ-048 int_flush while in DATA, data_ok arriving 3 cycles later -> FSM passes through DRAIN to IDLE, no mem_rdata_valid pulse, and a following load is issued only after IDLE is reached.
REQ-049 Reset asserted while in ADDR -> next cycle FSM in IDLE with data_req = 0 and mem_stall = 0.
